// File: rtl/fifo_rr_sched.sv
// Weighted round-robin read scheduler draining NQ register FIFOs into one
// valid/ready stream; a 2-entry buffer absorbs the 1-cycle FIFO read latency.
module fifo_rr_sched #(
  parameter  int NQ      = 4,
  parameter  int WIDTH   = 8,
  parameter  int ADDRBIT = 4,
  parameter  int BURST   = 4,
  localparam int QW      = (NQ > 1) ? $clog2(NQ) : 1,
  localparam int LW      = ADDRBIT + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NQ-1:0]       cfg_qen,
  input  logic [LW-1:0]       cfg_hiwat,
  input  logic [NQ-1:0]       q_notempty,
  input  logic [NQ*LW-1:0]    q_len,
  input  logic [NQ*WIDTH-1:0] q_dout,
  output logic [NQ-1:0]       q_rd,
  output logic                out_vld,
  output logic [WIDTH-1:0]    out_dat,
  output logic [QW-1:0]       out_qid,
  input  logic                out_rdy,
  output logic                busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                     state, state_nx;
  logic [QW-1:0]              rr_ptr, rr_nx, gq, gq_nx, rd_q, inf_qid;
  logic [7:0]                 bcnt, bcnt_nx;
  logic                       rd_en, inflight, pop, credit;
  logic [1:0]                 buf_cnt;
  logic [2:0]                 occ;
  logic [1:0][WIDTH-1:0]      b_dat;
  logic [1:0][QW-1:0]         b_qid;
  logic [NQ-1:0]              elig, urg;
  logic                       pick_u, pick_e;
  logic [QW-1:0]              pick_uq, pick_eq;
  logic [WIDTH-1:0]           cap_dat;
  int                         idx;

  assign elig = cfg_qen & q_notempty;

  for (genvar i = 0; i < NQ; i++) begin : g_urg
    assign urg[i] = elig[i] & (cfg_hiwat != '0) & (q_len[i*LW +: LW] >= cfg_hiwat);
  end

  assign pop    = out_vld & out_rdy;
  assign occ    = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign credit = (occ < 3'd2);

  // First urgent and first eligible queue, both searched from rr_ptr with wrap.
  always_comb begin
    pick_u  = 1'b0;
    pick_e  = 1'b0;
    pick_uq = '0;
    pick_eq = '0;
    idx     = 0;
    for (int k = 0; k < NQ; k++) begin
      idx = (int'(rr_ptr) + k) % NQ;
      if (!pick_u && urg[idx[QW-1:0]]) begin
        pick_u  = 1'b1;
        pick_uq = idx[QW-1:0];
      end
      if (!pick_e && elig[idx[QW-1:0]]) begin
        pick_e  = 1'b1;
        pick_eq = idx[QW-1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    gq_nx    = gq;
    bcnt_nx  = bcnt;
    rr_nx    = rr_ptr;
    rd_en    = 1'b0;
    rd_q     = gq;
    case (state)
      IDLE: if (credit && pick_e) begin
        rd_en    = 1'b1;
        rd_q     = pick_u ? pick_uq : pick_eq;
        gq_nx    = rd_q;
        bcnt_nx  = 8'd1;
        state_nx = GRANT;
      end
      GRANT: begin
        // End condition wins over credit: a stalled grant still ends when drained.
        if (!elig[gq] || bcnt == 8'(BURST)) begin
          rr_nx    = (gq == QW'(NQ - 1)) ? '0 : gq + 1'b1;
          state_nx = IDLE;
        end else if (credit) begin
          rd_en   = 1'b1;
          bcnt_nx = bcnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (rst) rd_en = 1'b0;
  end

  always_comb begin
    q_rd = '0;
    for (int i = 0; i < NQ; i++) q_rd[i] = rd_en && (rd_q == QW'(i));
  end

  assign cap_dat = q_dout[inf_qid*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gq       <= '0;
      bcnt     <= '0;
      inflight <= 1'b0;
      inf_qid  <= '0;
      buf_cnt  <= '0;
      b_dat    <= '0;
      b_qid    <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_nx;
      gq       <= gq_nx;
      bcnt     <= bcnt_nx;
      inflight <= rd_en;
      if (rd_en) inf_qid <= rd_q;
      case ({inflight, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            b_dat[0] <= cap_dat;
            b_qid[0] <= inf_qid;
          end else begin
            b_dat[1] <= cap_dat;
            b_qid[1] <= inf_qid;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          b_dat[0] <= b_dat[1];
          b_qid[0] <= b_qid[1];
          buf_cnt  <= buf_cnt - 2'd1;
        end
        2'b11: begin
          // Same-cycle capture and pop: occupancy unchanged, new word goes behind.
          if (buf_cnt == 2'd1) begin
            b_dat[0] <= cap_dat;
            b_qid[0] <= inf_qid;
          end else begin
            b_dat[0] <= b_dat[1];
            b_qid[0] <= b_qid[1];
            b_dat[1] <= cap_dat;
            b_qid[1] <= inf_qid;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_vld = (buf_cnt != 2'd0);
  assign out_dat = b_dat[0];
  assign out_qid = b_qid[0];
  assign busy    = (state == GRANT) | inflight | out_vld | (|q_rd);

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Scoreboard bench for fifo_rr_sched: behavioural register FIFOs feed the DUT,
// directed scenarios push expected words, a monitor pops and compares.
module tb_fifo_rr_sched;
  localparam int NQ = 4, W = 8, AB = 4, LW = AB + 1, BURST = 4;

  typedef struct packed {
    logic [1:0]   qid;
    logic [W-1:0] dat;
  } exp_t;

  logic             clk = 1'b0, rst;
  logic [NQ-1:0]    cfg_qen, q_notempty, q_rd;
  logic [LW-1:0]    cfg_hiwat;
  logic [NQ*LW-1:0] q_len;
  logic [NQ*W-1:0]  q_dout;
  logic             out_vld, out_rdy, busy;
  logic [W-1:0]     out_dat;
  logic [1:0]       out_qid;

  logic [NQ-1:0]    ld;
  logic [W-1:0]     ld_dat;
  logic [W-1:0]     mem    [NQ][32];
  logic [4:0]       rp     [NQ] = '{default: '0};
  logic [4:0]       wp     [NQ] = '{default: '0};
  logic [5:0]       cnt    [NQ] = '{default: '0};
  logic [W-1:0]     dout_r [NQ] = '{default: '0};

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   strobes[NQ] = '{default: 0};
  int   snap[NQ];

  always #5 clk = ~clk;

  fifo_rr_sched #(.NQ(NQ), .WIDTH(W), .ADDRBIT(AB), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .cfg_qen(cfg_qen), .cfg_hiwat(cfg_hiwat),
    .q_notempty(q_notempty), .q_len(q_len), .q_dout(q_dout), .q_rd(q_rd),
    .out_vld(out_vld), .out_dat(out_dat), .out_qid(out_qid),
    .out_rdy(out_rdy), .busy(busy)
  );

  // Register FIFOs: read data one cycle after the strobe, zero otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (q_rd[i] && cnt[i] != 0) begin
        dout_r[i] <= mem[i][rp[i]];
        rp[i]     <= rp[i] + 5'd1;
      end else dout_r[i] <= '0;
      if (ld[i]) begin
        mem[i][wp[i]] <= ld_dat;
        wp[i]         <= wp[i] + 5'd1;
      end
      cnt[i] <= cnt[i] + 6'(ld[i]) - 6'(q_rd[i] && cnt[i] != 0);
    end
  end

  always_comb begin
    q_notempty = '0;
    q_len      = '0;
    q_dout     = '0;
    for (int i = 0; i < NQ; i++) begin
      q_notempty[i]       = (cnt[i] != 0);
      q_len[i*LW +: LW]   = cnt[i][LW-1:0];
      q_dout[i*W +: W]    = dout_r[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: strobe accounting plus scoreboard pop on every accepted word.
  always @(negedge clk) begin
    if (!rst) begin
      if (!$onehot0(q_rd)) chk("rd_onehot", 32'(q_rd), 32'h1);
      for (int i = 0; i < NQ; i++) strobes[i] += int'(q_rd[i]);
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) chk("extra_word", {out_qid, out_dat}, 32'hFFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_qid", 32'(out_qid), 32'(e.qid));
          chk("out_dat", 32'(out_dat), 32'(e.dat));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int q, input int n);
    for (int k = 0; k < n; k++) begin
      ld     = NQ'(1) << q;
      ld_dat = W'(q * 16 + k);
      step();
    end
    ld = '0;
  endtask

  task automatic expect_words(input int q, input int n0, input int n1);
    for (int k = n0; k <= n1; k++) exp_q.push_back('{qid: 2'(q), dat: W'(q * 16 + k)});
  endtask

  task automatic take_snap();
    for (int i = 0; i < NQ; i++) snap[i] = strobes[i];
  endtask

  task automatic drain(input string name, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk(name, 32'(done), 32'h1);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [NQ-1:0] rd_h [6];
  logic          vld_h[6], bz_h[6];

  initial begin
    rst = 1'b1; cfg_qen = '0; cfg_hiwat = '0; out_rdy = 1'b1; ld = '0; ld_dat = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_q_rd", 32'(q_rd), 0);
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_out_dat", 32'(out_dat), 0);
    chk("rst_out_qid", 32'(out_qid), 0);
    chk("rst_busy", 32'(busy), 0);
    step();

    // Single queue, 3 words: back-to-back strobes, 2-cycle strobe-to-valid
    load(0, 3);
    expect_words(0, 0, 2);
    cfg_qen = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rd_h[k] = q_rd; vld_h[k] = out_vld; bz_h[k] = busy;
      step();
    end
    for (int k = 0; k < 3; k++) chk("t1_strobe", 32'(rd_h[k]), 32'h1);
    chk("t1_no_4th", 32'(rd_h[3]), 0);
    chk("t1_vld_k1", 32'(vld_h[1]), 0);
    chk("t1_vld_k2", 32'(vld_h[2]), 1);
    chk("t1_busy_k4", 32'(bz_h[4]), 1);
    chk("t1_busy_k5", 32'(bz_h[5]), 0);
    drain("t1_drain", 40);

    // Four full queues: bursts of 4 in rotation, final round of 2 each
    do_reset();
    cfg_qen = '0;
    for (int q = 0; q < NQ; q++) load(q, 10);
    for (int q = 0; q < NQ; q++) expect_words(q, 0, 3);
    for (int q = 0; q < NQ; q++) expect_words(q, 4, 7);
    for (int q = 0; q < NQ; q++) expect_words(q, 8, 9);
    take_snap();
    cfg_qen = 4'hF;
    drain("t2_drain", 300);
    for (int q = 0; q < NQ; q++) chk("t2_strobes", 32'(strobes[q] - snap[q]), 10);

    // Back-pressure: credit limits to 2 strobes, head word holds
    do_reset();
    out_rdy = 1'b0;
    cfg_qen = '0;
    load(1, 5);
    expect_words(1, 0, 4);
    take_snap();
    cfg_qen = 4'hF;
    repeat (8) step();
    @(negedge clk);
    chk("t3_rd_idle", 32'(q_rd), 0);
    chk("t3_vld", 32'(out_vld), 1);
    chk("t3_hold_dat", 32'(out_dat), 32'h10);
    chk("t3_hold_qid", 32'(out_qid), 1);
    step();
    chk("t3_strobes", 32'(strobes[1] - snap[1]), 2);
    out_rdy = 1'b1;
    drain("t3_drain", 60);
    chk("t3_strobes_all", 32'(strobes[1] - snap[1]), 5);

    // Urgency: q2 above watermark wins over q0; afterwards rr resumes at q3
    do_reset();
    cfg_qen = '0;
    load(0, 3); load(2, 12); load(3, 2);
    cfg_hiwat = 5'd10;
    expect_words(2, 0, 3); expect_words(3, 0, 1); expect_words(0, 0, 2);
    expect_words(2, 4, 7); expect_words(2, 8, 11);
    cfg_qen = 4'hF;
    @(negedge clk);
    chk("t4_urgent_first", 32'(q_rd), 32'h4);
    step();
    drain("t4_drain", 150);
    cfg_hiwat = '0;

    // Disable q1 mid-grant: no third strobe, in-flight words still delivered
    do_reset();
    cfg_qen = '0;
    load(1, 5);
    take_snap();
    cfg_qen = 4'hF;
    @(negedge clk); chk("t5_rd0", 32'(q_rd), 32'h2); step();
    @(negedge clk); chk("t5_rd1", 32'(q_rd), 32'h2); step();
    cfg_qen = 4'b1101;
    @(negedge clk); chk("t5_no_3rd", 32'(q_rd), 0);
    expect_words(1, 0, 1);
    step();
    drain("t5_drain", 40);
    chk("t5_strobes", 32'(strobes[1] - snap[1]), 2);
    cfg_qen = 4'hF;
    expect_words(1, 2, 4);
    drain("t5_rest", 40);

    // Reset mid-operation (pointer left at 2): state cleared, restart at q0
    out_rdy = 1'b0;
    cfg_qen = '0;
    load(0, 5);
    take_snap();
    cfg_qen = 4'hF;
    step(); step();
    rst = 1'b1; cfg_qen = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_q_rd", 32'(q_rd), 0);
    chk("t6_out_vld", 32'(out_vld), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_strobes", 32'(strobes[0] - snap[0]), 2);
    step();
    load(2, 2);
    expect_words(0, 2, 4); expect_words(2, 0, 1);
    out_rdy = 1'b1;
    cfg_qen = 4'hF;
    @(negedge clk);
    chk("t6_resume_q0", 32'(q_rd), 32'h1);
    step();
    drain("t6_drain", 60);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
